// File: rtl/gpmc_if.sv
// Command/response handshake and GPMC pin bundle shared by the master and
// whatever sits on the far side (SoC pads, responder model).
interface gpmc_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  done;
   logic [DATA_WIDTH-1:0] gpmc_ad_out;
   logic                  gpmc_ad_oe;
   logic [DATA_WIDTH-1:0] gpmc_ad_in;
   logic                  gpmc_csn1;
   logic                  gpmc_advn;
   logic                  gpmc_wein;
   logic                  gpmc_oen;
   logic                  gpmc_clk;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, gpmc_ad_in,
      output cmd_ready, rsp_valid, rsp_rdata, done,
             gpmc_ad_out, gpmc_ad_oe, gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_clk
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, gpmc_ad_in,
      input  cmd_ready, rsp_valid, rsp_rdata, done,
             gpmc_ad_out, gpmc_ad_oe, gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_clk
   );
endinterface

// File: rtl/gpmc_master.sv
// Single-beat multiplexed-AD GPMC master: address, access, recovery phases
// with fixed cycle counts; every bus-facing output comes straight from a flop.
module gpmc_master #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 16,
   parameter int ADV_CYC    = 2,
   parameter int ACC_CYC    = 3,
   parameter int REC_CYC    = 2
) (
   input logic    clk,
   input logic    rst_n,
   gpmc_if.master bus
);
   localparam int MAXC = (ADV_CYC > ACC_CYC) ? ((ADV_CYC > REC_CYC) ? ADV_CYC : REC_CYC)
                                             : ((ACC_CYC > REC_CYC) ? ACC_CYC : REC_CYC);
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RECOVER} state_t;
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   state_t  state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   cmd_t    cmd_q, cmd_nx;
   logic    accept, acc_end;

   logic                  csn1_n, advn_n, wein_n, oen_n, oe_n, gclk_n;
   logic [DATA_WIDTH-1:0] ad_n;

   assign accept  = bus.cmd_valid && bus.cmd_ready;
   assign acc_end = (state == ACCESS) && (state_n == RECOVER);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      cmd_nx  = accept ? cmd_t'{bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} : cmd_q;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (accept) state_n = ADDR;
         end
         ADDR:    if (cnt == CW'(ADV_CYC - 1)) begin state_n = ACCESS;  cnt_n = '0; end
         ACCESS:  if (cnt == CW'(ACC_CYC - 1)) begin state_n = RECOVER; cnt_n = '0; end
         default: if (cnt == CW'(REC_CYC - 1)) begin state_n = IDLE;    cnt_n = '0; end
      endcase
   end

   // Pin values for the cycle we are about to enter, so they can be registered.
   always_comb begin
      csn1_n = 1'b1;
      advn_n = 1'b1;
      wein_n = 1'b1;
      oen_n  = 1'b1;
      oe_n   = 1'b0;
      ad_n   = '0;
      gclk_n = 1'b0;
      case (state_n)
         ADDR: begin
            csn1_n = 1'b0;
            advn_n = 1'b0;
            oe_n   = 1'b1;
            ad_n   = DATA_WIDTH'(cmd_nx.addr);
         end
         ACCESS: begin
            csn1_n = 1'b0;
            if (cmd_nx.we) begin
               wein_n = 1'b0;
               oe_n   = 1'b1;
               ad_n   = cmd_nx.wdata;
            end else begin
               oen_n  = 1'b0;
            end
         end
         default: ;
      endcase
      // Bus clock restarts high on the first address cycle, then toggles while selected.
      if (state_n == ADDR || state_n == ACCESS)
         gclk_n = (state == IDLE) ? 1'b1 : ~bus.gpmc_clk;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         cmd_q           <= '0;
         bus.cmd_ready   <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.done        <= 1'b0;
         bus.gpmc_ad_out <= '0;
         bus.gpmc_ad_oe  <= 1'b0;
         bus.gpmc_csn1   <= 1'b1;
         bus.gpmc_advn   <= 1'b1;
         bus.gpmc_wein   <= 1'b1;
         bus.gpmc_oen    <= 1'b1;
         bus.gpmc_clk    <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         cmd_q           <= cmd_nx;
         bus.cmd_ready   <= (state_n == IDLE);
         bus.done        <= acc_end;
         bus.rsp_valid   <= acc_end && !cmd_q.we;
         if (acc_end && !cmd_q.we) bus.rsp_rdata <= bus.gpmc_ad_in;
         bus.gpmc_ad_out <= ad_n;
         bus.gpmc_ad_oe  <= oe_n;
         bus.gpmc_csn1   <= csn1_n;
         bus.gpmc_advn   <= advn_n;
         bus.gpmc_wein   <= wein_n;
         bus.gpmc_oen    <= oen_n;
         bus.gpmc_clk    <= gclk_n;
      end
   end
endmodule
